// File: rtl/fifo_read_packer_pkg.sv
// Shared defaults, types and helpers for the FIFO read-side packer.
package fifo_read_packer_pkg;

  localparam int DATA_SIZE_DEF  = 8;
  localparam int PACK_RATIO_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;
  localparam int WORD_W         = DATA_SIZE_DEF * PACK_RATIO_DEF;

  typedef logic [PACK_RATIO_DEF-1:0] keep_t;

  // Low-order mask with n ones: the lanes filled so far in a partial word.
  function automatic logic [31:0] keep_mask(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_read_packer_pack_idle_timer.sv
// Counts consecutive idle cycles of a partly filled word; saturates at TIMEOUT.
module pack_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LIMIT = IW'(TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;

  // Clear wins over counting; the count holds once it reaches the limit.
  always_comb begin
    idle_d = idle_q;
    if (clear) begin
      idle_d = '0;
    end else if (run && (idle_q != LIMIT)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign expired = (idle_q == LIMIT);

endmodule

// File: rtl/fifo_read_packer.sv
// Pops FIFO entries and packs PACK_RATIO of them LSB-first into one output
// word on a valid/ready interface; partial words leave on idle timeout or flush.
module fifo_read_packer
  import fifo_read_packer_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int PACK_RATIO = PACK_RATIO_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                            rclk,
  input  logic                            rrst,
  input  logic [DATA_SIZE-1:0]            rData,
  input  logic                            rEmpty,
  output logic                            rinc,
  input  logic                            flush,
  output logic [DATA_SIZE*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]           out_keep,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int CW = $clog2(PACK_RATIO);
  localparam int OW = DATA_SIZE * PACK_RATIO;
  localparam logic [CW-1:0] LAST = CW'(PACK_RATIO - 1);

  logic [DATA_SIZE-1:0]  lane_q [PACK_RATIO-1];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [OW-1:0]         out_data_q, out_data_d;
  logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
  logic [OW-1:0]         full_w, part_w;
  logic                  slot_free, pop, emit, expired;

  // The output register can take a new word if empty or draining this cycle.
  // out_ready reaches rinc combinationally so a full word can move every cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign pop       = !rrst && !rEmpty && !flush_pend_q && ((cnt_q < LAST) || slot_free);
  assign emit      = flush_pend_q && slot_free;
  assign rinc      = pop;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle (
    .clk     (rclk),
    .rst     (rrst),
    .run     ((cnt_q != '0) && !pop),
    .clear   (pop || emit || (cnt_q == '0)),
    .expired (expired)
  );

  // Candidate output words: complete (head entry as top lane) and partial (zero-filled above cnt).
  always_comb begin
    full_w = '0;
    part_w = '0;
    for (int i = 0; i < PACK_RATIO - 1; i++) begin
      full_w[i*DATA_SIZE +: DATA_SIZE] = lane_q[i];
      if (CW'(i) < cnt_q) begin
        part_w[i*DATA_SIZE +: DATA_SIZE] = lane_q[i];
      end
    end
    full_w[(PACK_RATIO-1)*DATA_SIZE +: DATA_SIZE] = rData;
  end

  // Next state: pop into a lane or complete a word, otherwise emit a pending partial.
  always_comb begin
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    if (pop) begin
      if (cnt_q == LAST) begin
        out_data_d  = full_w;
        out_keep_d  = '1;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (emit) begin
      out_data_d   = part_w;
      out_keep_d   = PACK_RATIO'(keep_mask(int'(cnt_q)));
      out_valid_d  = 1'b1;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
    // A flush or timeout applies to the count after this cycle's pop.
    if (!flush_pend_q && (flush || expired) && (cnt_d != '0)) begin
      flush_pend_d = 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
    end
  end

  // Lane register file; only lanes below the top are stored.
  always_ff @(posedge rclk) begin
    for (int i = 0; i < PACK_RATIO - 1; i++) begin
      if (pop && (cnt_q == CW'(i))) begin
        lane_q[i] <= rData;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: FIFO model, directed scenarios and a random soak.
module tb_fifo_read_packer;
  import fifo_read_packer_pkg::*;

  logic              rclk = 1'b0;
  logic              rrst;
  logic [7:0]        rData;
  logic              rEmpty;
  logic              rinc;
  logic              flush;
  logic [WORD_W-1:0] out_data;
  keep_t             out_keep;
  logic              out_valid;
  logic              out_ready;

  always #5 rclk = ~rclk;

  fifo_read_packer #(
    .DATA_SIZE  (8),
    .PACK_RATIO (4),
    .TIMEOUT    (16)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rData     (rData),
    .rEmpty    (rEmpty),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] fifo[$];
  logic [7:0] exp_s[$];
  int pops = 0;
  int hs = 0;
  int bytes_out = 0;
  logic [WORD_W-1:0] last_data;
  keep_t last_keep;
  bit pop_now;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    rEmpty = (fifo.size() == 0);
    rData  = (fifo.size() != 0) ? fifo[0] : 8'hEE;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    exp_s.push_back(b);
    drive_fifo();
  endtask

  // Every accepted word must carry the next bytes of the written stream, in order.
  task automatic score();
    int k;
    hs++;
    last_data = out_data;
    last_keep = out_keep;
    k = $countones(out_keep);
    chk("keep_nonzero", 64'(out_keep != 0), 64'd1);
    chk("keep_contig", 64'(out_keep), 64'((64'd1 << k) - 64'd1));
    for (int i = 0; i < 4; i++) begin
      if (i < k) begin
        checks++;
        assert (exp_s.size() > 0) else begin
          failures++;
          $error("FAIL lane_extra observed=0x%0h expected=none", out_data[i*8 +: 8]);
        end
        if (exp_s.size() > 0) chk("lane_data", 64'(out_data[i*8 +: 8]), 64'(exp_s.pop_front()));
      end else begin
        chk("lane_pad", 64'(out_data[i*8 +: 8]), 64'd0);
      end
    end
    bytes_out += k;
  endtask

  task automatic tick();
    @(negedge rclk);
    pop_now = rinc && !rEmpty;
    chk("rinc_while_empty", 64'(rinc && rEmpty), 64'd0);
    if (out_valid && out_ready) score();
    @(posedge rclk);
    #1;
    if (pop_now) begin
      void'(fifo.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  initial begin
    int n;
    int p0;
    int h0;
    int sent;
    rrst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_fifo();

    // Reset: no pops while rrst is high even with data present
    push(8'h11);
    #1;
    chk("rst_rinc", 64'(rinc), 64'd0);
    repeat (2) tick();
    chk("rst_pops", 64'(pops), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_keep", 64'(out_keep), 64'd0);

    // Full word at full throughput
    push(8'h22); push(8'h33); push(8'h44);
    out_ready = 1'b1;
    rrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fw_pop", 64'(pop_now), 64'd1);
      if (i < 3) chk("fw_not_yet", 64'(out_valid), 64'd0);
    end
    chk("fw_valid", 64'(out_valid), 64'd1);
    chk("fw_data", 64'(out_data), 64'h44332211);
    chk("fw_keep", 64'(out_keep), 64'hF);
    tick();
    chk("fw_drained", 64'(out_valid), 64'd0);
    chk("fw_hs", 64'(hs), 64'd1);

    // Backpressure: word 1 held, three more pops then stall
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i >= 4) begin
        chk("bp_hold_data", 64'(out_data), 64'h44332211);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
      end
    end
    chk("bp_pops", 64'(pops - p0), 64'd7);
    chk("bp_rinc_low", 64'(rinc), 64'd0);
    chk("bp_keep", 64'(out_keep), 64'hF);
    out_ready = 1'b1;
    #1;
    chk("bp_rinc_comb", 64'(rinc), 64'd1);
    tick();
    chk("bp_pop4", 64'(pop_now), 64'd1);
    chk("bp_word2_valid", 64'(out_valid), 64'd1);
    chk("bp_word2_data", 64'(out_data), 64'h88776655);
    tick();
    chk("bp_last", 64'(last_data), 64'h88776655);

    // Idle timeout on a two-entry partial word
    push(8'hAA); push(8'hBB);
    tick(); tick();
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_min_latency", 64'(n >= 16), 64'd1);
    chk("to_max_latency", 64'(n <= 19), 64'd1);
    chk("to_data", 64'(out_data), 64'h0000BBAA);
    chk("to_keep", 64'(out_keep), 64'b0011);
    tick();

    // Flush of a three-entry partial word
    push(8'h01); push(8'h02); push(8'h03);
    repeat (3) tick();
    chk("fl_before", 64'(out_valid), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (!out_valid && n < 5) begin
      tick();
      n++;
    end
    chk("fl_valid", 64'(out_valid), 64'd1);
    chk("fl_data", 64'(out_data), 64'h00030201);
    chk("fl_keep", 64'(out_keep), 64'b0111);
    tick();

    // Flush with nothing pending produces no word
    h0 = hs;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("fl0_valid", 64'(out_valid), 64'd0);
    end
    chk("fl0_hs", 64'(hs), 64'(h0));

    // Reset mid-word discards the partial lanes
    push(8'hC1); push(8'hC2);
    tick(); tick();
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    chk("rm_valid", 64'(out_valid), 64'd0);
    chk("rm_lost", 64'(exp_s.size()), 64'd2);
    exp_s.delete();
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    repeat (4) tick();
    chk("rm_data", 64'(out_data), 64'h88776655);
    chk("rm_keep", 64'(out_keep), 64'hF);
    tick();

    // Soak: random write gaps, backpressure and occasional flush
    bytes_out = 0;
    sent = 0;
    n = 0;
    while ((sent < 840 || fifo.size() != 0) && n < 20000) begin
      if (sent < 840 && $urandom_range(0, 9) < 6) begin
        push(8'($urandom));
        sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      tick();
      n++;
    end
    flush = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_s.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("soak_bytes", 64'(bytes_out), 64'd840);
    chk("soak_left", 64'(exp_s.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
